// File: rtl/exe_stage.sv
// Execute stage of the in-order MIPS pipeline: ALU, data-SRAM request issue, and an
// iterative 32-step restoring divider that owns HI/LO.
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_allowin,
    output logic         es_allowin,
    input  logic         ds_to_es_valid,
    input  logic [140:0] ds_to_es_bus,
    output logic         es_to_ms_valid,
    output logic [70:0]  es_to_ms_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic [4:0]   es_dest,
    output logic         es_val,
    output logic         es_gr_we,
    output logic         es_res_from_mem,
    output logic [31:0]  es_result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    div_state_t   div_state, div_next;
    logic         es_valid;
    logic [140:0] bus_p0;
    logic         es_ready_go, latch, handoff, div_load;

    logic [11:0] alu_op;
    logic [1:0]  div_op;
    logic        mfhi, mflo, load, src1_is_sa, src1_is_pc;
    logic        src2_is_imm, src2_is_uimm, src2_is_8, gr_we, mem_we;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rs_value, rt_value, pc;

    assign {alu_op, div_op, mfhi, mflo, load, src1_is_sa, src1_is_pc, src2_is_imm,
            src2_is_uimm, src2_is_8, gr_we, mem_we, dest, imm, rs_value, rt_value, pc} = bus_p0;

    // Stage p0: handshake and bundle latch
    assign es_ready_go    = !(|div_op) || (div_state == DONE);
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign latch          = ds_to_es_valid && es_allowin;
    assign handoff        = es_valid && es_ready_go && ms_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds_to_es_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            bus_p0 <= ds_to_es_bus;
        end
    end

    // ALU
    logic [31:0]        src1, src2, add_res, sub_res, slt_res, sltu_res, sra_res, alu_res;
    logic signed [31:0] src1_s, src2_s;

    assign src1 = src1_is_sa ? {27'b0, imm[10:6]} : src1_is_pc ? pc : rs_value;
    assign src2 = src2_is_imm  ? {{16{imm[15]}}, imm} :
                  src2_is_uimm ? {16'b0, imm} :
                  src2_is_8    ? 32'd8 : rt_value;
    assign src1_s   = src1;
    assign src2_s   = src2;
    assign add_res  = src1 + src2;
    assign sub_res  = src1 - src2;
    assign slt_res  = {31'b0, src1_s < src2_s};
    assign sltu_res = {31'b0, src1 < src2};
    assign sra_res  = src2_s >>> src1[4:0];

    always_comb begin
        alu_res = ({32{alu_op[11]}} & add_res)
                | ({32{alu_op[10]}} & sub_res)
                | ({32{alu_op[9]}}  & slt_res)
                | ({32{alu_op[8]}}  & sltu_res)
                | ({32{alu_op[7]}}  & (src1 & src2))
                | ({32{alu_op[6]}}  & ~(src1 | src2))
                | ({32{alu_op[5]}}  & (src1 | src2))
                | ({32{alu_op[4]}}  & (src1 ^ src2))
                | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
                | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
                | ({32{alu_op[1]}}  & sra_res)
                | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});
    end

    // Divider: operands are captured straight off the decode bus so step 0 runs in cycle 0
    logic        in_div, in_signed;
    logic [31:0] in_rs, in_rt;
    logic [32:0] div_rem;
    logic [31:0] div_quo, div_dvs, quo_fix, rem_fix;
    logic [33:0] div_shift, div_trial;
    logic [5:0]  div_cnt;
    logic        neg_q, neg_r;
    logic [31:0] hi, lo;

    assign in_div    = |ds_to_es_bus[128:127];
    assign in_signed = ds_to_es_bus[128];
    assign in_rs     = ds_to_es_bus[95:64];
    assign in_rt     = ds_to_es_bus[63:32];

    always_ff @(posedge clk) begin
        if (reset) begin
            div_state <= IDLE;
        end else begin
            div_state <= div_next;
        end
    end

    always_comb begin
        div_next = div_state;
        div_load = 1'b0;
        case (div_state)
            IDLE, DONE: begin
                if (latch && in_div) begin
                    div_next = BUSY;
                    div_load = 1'b1;
                end else if (div_state == DONE && handoff) begin
                    div_next = IDLE;
                end
            end
            BUSY:    if (div_cnt == 6'd31) div_next = DONE;
            default: div_next = IDLE;
        endcase
    end

    assign div_shift = {div_rem, div_quo[31]};
    assign div_trial = div_shift - {2'b0, div_dvs};

    always_ff @(posedge clk) begin
        if (div_load) begin
            div_quo <= cond_neg(in_rs, in_signed && in_rs[31]);
            div_dvs <= cond_neg(in_rt, in_signed && in_rt[31]);
            div_rem <= '0;
            div_cnt <= '0;
            neg_q   <= in_signed && (in_rs[31] ^ in_rt[31]);
            neg_r   <= in_signed && in_rs[31];
        end else if (div_state == BUSY) begin
            div_rem <= div_trial[33] ? div_shift[32:0] : div_trial[32:0];
            div_quo <= {div_quo[30:0], ~div_trial[33]};
            div_cnt <= div_cnt + 6'd1;
        end
    end

    assign quo_fix = cond_neg(div_quo, neg_q);
    assign rem_fix = cond_neg(div_rem[31:0], neg_r);

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (div_state == DONE && handoff) begin
            hi <= rem_fix;
            lo <= quo_fix;
        end
    end

    // Outputs
    assign es_result       = mfhi ? hi : mflo ? lo : alu_res;
    assign es_to_ms_bus    = {load, gr_we, dest, es_result, pc};
    assign es_dest         = dest;
    assign es_val          = es_valid;
    assign es_gr_we        = gr_we;
    assign es_res_from_mem = load;
    assign data_sram_en    = es_valid && (load || mem_we) && ms_allowin;
    assign data_sram_wen   = {4{es_valid && mem_we && ms_allowin}};
    assign data_sram_addr  = add_res;
    assign data_sram_wdata = rt_value;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed vectors, table-driven ALU checks, randomized ALU and
// divide traffic compared with an arithmetic reference model.
module tb_exe_stage;

    logic         clk = 1'b0;
    logic         reset, ms_allowin, es_allowin, ds_to_es_valid, es_to_ms_valid;
    logic [140:0] ds_to_es_bus;
    logic [70:0]  es_to_ms_bus;
    logic         data_sram_en, es_val, es_gr_we, es_res_from_mem;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata, es_result;
    logic [4:0]   es_dest;

    int errors = 0;
    int checks = 0;

    exe_stage dut (
        .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .es_dest(es_dest), .es_val(es_val), .es_gr_we(es_gr_we),
        .es_res_from_mem(es_res_from_mem), .es_result(es_result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // sel = {src1_is_sa, src1_is_pc, src2_is_imm, src2_is_uimm, src2_is_8}
    function automatic logic [140:0] mk(input logic [11:0] alu, input logic [1:0] dop,
                                        input logic hi_rd, input logic lo_rd, input logic ld,
                                        input logic [4:0] sel, input logic gw, input logic mw,
                                        input logic [4:0] dst, input logic [15:0] imm,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [31:0] pc);
        return {alu, dop, hi_rd, lo_rd, ld, sel, gw, mw, dst, imm, rs, rt, pc};
    endfunction

    // op index 0..11 = add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui
    function automatic logic [31:0] ref_alu(input int op, input logic [4:0] sel,
                                            input logic [15:0] imm, input logic [31:0] rs,
                                            input logic [31:0] rt, input logic [31:0] pc);
        logic [31:0] a, b;
        int sh;
        a  = sel[4] ? 32'(imm[10:6]) : sel[3] ? pc : rs;
        b  = sel[2] ? {{16{imm[15]}}, imm} : sel[1] ? {16'h0, imm} : sel[0] ? 32'd8 : rt;
        sh = int'(a % 32);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return b << sh;
            9:  return b >> sh;
            10: return $signed(b) >>> sh;
            default: return b * 32'd65536;
        endcase
    endfunction

    task automatic run_alu(input string name, input logic [140:0] b, input logic [31:0] exp);
        @(negedge clk);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = b;
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        chk({name, "_vld"}, 32'(es_to_ms_valid), 32'd1);
        chk({name, "_res"}, es_to_ms_bus[63:32], exp);
    endtask

    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] d, input int stall, input logic chk_vals);
        logic [31:0] eq, er;
        int cyc, bad;
        eq = '0;
        er = '0;
        if (chk_vals) begin
            if (sgn) begin
                eq = $signed(a) / $signed(d);
                er = $signed(a) % $signed(d);
            end else begin
                eq = a / d;
                er = a % d;
            end
        end
        ms_allowin = 1'b1;
        @(negedge clk);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(12'h0, sgn ? 2'b10 : 2'b01, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0,
                            5'd0, 16'h0, a, d, 32'h400);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        if (stall > 0) ms_allowin = 1'b0;
        cyc = 0;
        bad = 0;
        while (es_to_ms_valid !== 1'b1 && cyc < 200) begin
            if (es_allowin !== 1'b0) bad++;
            @(negedge clk);
            cyc++;
        end
        chk({name, "_lat"}, 32'(cyc), 32'd32);
        chk({name, "_busy_allowin"}, 32'(bad), 32'd0);
        for (int i = 0; i < stall; i++) begin
            chk({name, "_hold"}, {30'b0, es_to_ms_valid, es_allowin}, 32'd2);
            @(negedge clk);
        end
        ms_allowin = 1'b1;
        if (chk_vals) begin
            ds_to_es_valid = 1'b1;
            ds_to_es_bus   = mk(12'h0, 2'b00, 1'b0, 1'b1, 1'b0, 5'b0, 1'b1, 1'b0, 5'd3,
                                16'h0, 32'h0, 32'h0, 32'h404);
            #1;
            chk({name, "_handoff_allowin"}, 32'(es_allowin), 32'd1);
            @(negedge clk);
            ds_to_es_bus = mk(12'h0, 2'b00, 1'b1, 1'b0, 1'b0, 5'b0, 1'b1, 1'b0, 5'd4,
                              16'h0, 32'h0, 32'h0, 32'h408);
            chk({name, "_lo"}, es_to_ms_bus[63:32], eq);
            @(negedge clk);
            ds_to_es_valid = 1'b0;
            chk({name, "_hi"}, es_to_ms_bus[63:32], er);
        end
        @(negedge clk);
    endtask

    task automatic rand_alu(input int n);
        int op, s1, s2;
        logic [4:0]  sel;
        logic [15:0] imm;
        logic [31:0] rs, rt, pc;
        for (int i = 0; i < n; i++) begin
            op  = int'($urandom_range(0, 11));
            s1  = int'($urandom_range(0, 2));
            s2  = int'($urandom_range(0, 3));
            sel = {s1 == 1, s1 == 2, s2 == 1, s2 == 2, s2 == 3};
            imm = 16'($urandom);
            rs  = $urandom;
            rt  = $urandom;
            pc  = $urandom;
            run_alu("rnd_alu", mk(12'h800 >> op, 2'b00, 1'b0, 1'b0, 1'b0, sel, 1'b1, 1'b0,
                                  5'd9, imm, rs, rt, pc), ref_alu(op, sel, imm, rs, rt, pc));
        end
    endtask

    task automatic rand_div(input int n);
        logic        sgn;
        logic [31:0] a, d;
        for (int i = 0; i < n; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            d   = $urandom >> $urandom_range(0, 31);
            if (d == 32'h0) d = 32'h1;
            if (sgn && a == 32'h80000000 && d == 32'hFFFFFFFF) d = 32'h2;
            run_div("rnd_div", sgn, a, d, int'($urandom_range(0, 2)), 1'b1);
        end
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  sel;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pc;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t tbl [15];

    initial begin
        tbl[0]  = '{4'd0,  5'b00000, 16'h0000, 32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h80000000};
        tbl[1]  = '{4'd1,  5'b00000, 16'h0000, 32'h00000005, 32'h00000007, 32'h0, 32'hFFFFFFFE};
        tbl[2]  = '{4'd2,  5'b00000, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h00000001};
        tbl[3]  = '{4'd3,  5'b00000, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h00000000};
        tbl[4]  = '{4'd4,  5'b00000, 16'h0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h00F000F0};
        tbl[5]  = '{4'd5,  5'b00000, 16'h0000, 32'h00000000, 32'h00000000, 32'h0, 32'hFFFFFFFF};
        tbl[6]  = '{4'd6,  5'b00000, 16'h0000, 32'h12340000, 32'h00005678, 32'h0, 32'h12345678};
        tbl[7]  = '{4'd7,  5'b00000, 16'h0000, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 32'hF0F00F0F};
        tbl[8]  = '{4'd8,  5'b10000, 16'h0100, 32'hFFFFFFFF, 32'h0000000F, 32'h0, 32'h000000F0};
        tbl[9]  = '{4'd9,  5'b00000, 16'h0000, 32'h00000108, 32'h80000000, 32'h0, 32'h00800000};
        tbl[10] = '{4'd10, 5'b10000, 16'h0100, 32'h00000000, 32'h80000000, 32'h0, 32'hF8000000};
        tbl[11] = '{4'd11, 5'b00010, 16'hABCD, 32'h00000000, 32'h00000000, 32'h0, 32'hABCD0000};
        tbl[12] = '{4'd0,  5'b00100, 16'hFFFF, 32'h00000010, 32'h00000000, 32'h0, 32'h0000000F};
        tbl[13] = '{4'd0,  5'b01001, 16'h0000, 32'h00000000, 32'h00000000, 32'hBFC00000, 32'hBFC00008};
        tbl[14] = '{4'd6,  5'b00010, 16'h8000, 32'h00000000, 32'h00000000, 32'h0, 32'h00008000};

        reset          = 1'b1;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_es_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
        chk("rst_es_allowin", 32'(es_allowin), 32'd1);
        chk("rst_es_val", 32'(es_val), 32'd0);
        chk("rst_sram_en", 32'(data_sram_en), 32'd0);
        chk("rst_sram_wen", 32'(data_sram_wen), 32'd0);
        run_alu("rst_hi", mk(12'h0, 2'b00, 1'b1, 1'b0, 1'b0, 5'b0, 1'b1, 1'b0, 5'd1, 16'h0,
                             32'h0, 32'h0, 32'h0), 32'h0);
        run_alu("rst_lo", mk(12'h0, 2'b00, 1'b0, 1'b1, 1'b0, 5'b0, 1'b1, 1'b0, 5'd1, 16'h0,
                             32'h0, 32'h0, 32'h0), 32'h0);

        // addu with single-cycle residency
        run_alu("addu", mk(12'h800, 2'b00, 1'b0, 1'b0, 1'b0, 5'b0, 1'b1, 1'b0, 5'd8, 16'h0,
                           32'h7FFFFFFF, 32'h1, 32'h100), 32'h80000000);
        chk("addu_gr_we", 32'(es_to_ms_bus[69]), 32'd1);
        chk("addu_dest", 32'(es_to_ms_bus[68:64]), 32'd8);
        @(negedge clk);
        chk("addu_residency", 32'(es_val), 32'd0);

        // sw: request only in the handoff cycle
        run_alu("sw", mk(12'h800, 2'b00, 1'b0, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b1, 5'd0, 16'hFFFC,
                         32'h1000, 32'hDEADBEEF, 32'h104), 32'h00000FFC);
        chk("sw_en", 32'(data_sram_en), 32'd1);
        chk("sw_wen", 32'(data_sram_wen), 32'hF);
        chk("sw_addr", data_sram_addr, 32'h00000FFC);
        chk("sw_wdata", data_sram_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("sw_en_after", {27'b0, data_sram_en, data_sram_wen}, 32'd0);

        // lw under three cycles of back-pressure
        ms_allowin = 1'b0;
        @(negedge clk);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(12'h800, 2'b00, 1'b0, 1'b0, 1'b1, 5'b00100, 1'b1, 1'b0, 5'd5,
                            16'h0010, 32'h2000, 32'h0, 32'h108);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lw_stall_en", 32'(data_sram_en), 32'd0);
            chk("lw_stall_rfm", 32'(es_res_from_mem), 32'd1);
            chk("lw_stall_allowin", 32'(es_allowin), 32'd0);
            chk("lw_stall_addr", data_sram_addr, 32'h2010);
            @(negedge clk);
        end
        ms_allowin = 1'b1;
        #1;
        chk("lw_release_en", 32'(data_sram_en), 32'd1);
        chk("lw_release_wen", 32'(data_sram_wen), 32'd0);
        chk("lw_release_rfm", 32'(es_res_from_mem), 32'd1);
        chk("lw_release_bus_rfm", 32'(es_to_ms_bus[70]), 32'd1);
        @(negedge clk);
        chk("lw_gone", 32'(es_val), 32'd0);

        for (int i = 0; i < 15; i++) begin
            run_alu("tbl", mk(12'h800 >> tbl[i].op, 2'b00, 1'b0, 1'b0, 1'b0, tbl[i].sel, 1'b1,
                              1'b0, 5'd7, tbl[i].imm, tbl[i].rs, tbl[i].rt, tbl[i].pc),
                    tbl[i].exp);
        end
        rand_alu(120);

        run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 0, 1'b1);
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 4, 1'b1);

        // reset in cycle 10 of a divide
        @(negedge clk);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = mk(12'h0, 2'b10, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 5'd0, 16'h0,
                            32'd100, 32'd7, 32'h500);
        @(negedge clk);
        ds_to_es_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_es_val", 32'(es_val), 32'd0);
        chk("midrst_allowin", 32'(es_allowin), 32'd1);
        chk("midrst_to_ms", 32'(es_to_ms_valid), 32'd0);
        run_alu("midrst_hi", mk(12'h0, 2'b00, 1'b1, 1'b0, 1'b0, 5'b0, 1'b1, 1'b0, 5'd1, 16'h0,
                                32'h0, 32'h0, 32'h0), 32'h0);
        run_alu("midrst_lo", mk(12'h0, 2'b00, 1'b0, 1'b1, 1'b0, 5'b0, 1'b1, 1'b0, 5'd1, 16'h0,
                                32'h0, 32'h0, 32'h0), 32'h0);
        run_div("div_after_rst", 1'b1, 32'hFFFFFFEC, 32'd3, 0, 1'b1);

        rand_div(8);
        run_div("divu_by_zero", 1'b0, 32'h12345678, 32'h0, 0, 1'b0);
        run_div("div_by_zero", 1'b1, 32'h87654321, 32'h0, 1, 1'b0);
        run_div("div_after_zero", 1'b1, 32'h80000000, 32'h7FFFFFFF, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
